// File: rtl/plic_gateway.sv
// plic_gateway: per-source interrupt gateways feeding the PLIC priority tree.
// Each source turns a level or rising-edge line into one pending request.
// It holds that request until the target claims it and then completes it.
// Edges that arrive while a request is outstanding are counted and replayed.
// State encoding for the debug output (2 bits per source): 0=IDLE, 1=PENDING, 2=CLAIMED.
module plic_gateway #(
    parameter int SOURCES          = 31,
    parameter int EDGE_COUNT_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [SOURCES-1:0]   interrupt_source_i,
    input  logic [SOURCES-1:0]   interrupt_edge_mode_i,
    input  logic                 claim_valid_i,
    input  logic [31:0]          claim_id_i,
    input  logic                 complete_valid_i,
    input  logic [31:0]          complete_id_i,
    output logic [SOURCES-1:0]   interrupt_pending_o,
    output logic [SOURCES-1:0]   interrupt_in_service_o,
    output logic [SOURCES-1:0]   interrupt_edge_overflow_o,
    output logic [2*SOURCES-1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_CLAIMED = 2'd2
    } gw_state_e;

    localparam logic [EDGE_COUNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [EDGE_COUNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [EDGE_COUNT_WIDTH-1:0] CNT_ONE  = EDGE_COUNT_WIDTH'(1);

    gw_state_e                   state_q [SOURCES];
    gw_state_e                   state_d [SOURCES];
    logic [EDGE_COUNT_WIDTH-1:0] cnt_q   [SOURCES];
    logic [EDGE_COUNT_WIDTH-1:0] cnt_d   [SOURCES];
    logic [SOURCES-1:0]          prev_q, prev_d;
    logic [SOURCES-1:0]          mode_q, mode_d;
    logic [SOURCES-1:0]          pend_q, pend_d;
    logic [SOURCES-1:0]          svc_q, svc_d;
    logic [SOURCES-1:0]          ovf_q, ovf_d;

    logic [SOURCES-1:0]          rise;
    logic [SOURCES-1:0]          sat;
    logic [SOURCES-1:0]          mode_chg;
    logic [SOURCES-1:0]          claim_hit;
    logic [SOURCES-1:0]          complete_hit;

    // Next-state for every gateway: edge detect, edge counter, FSM and output decode.
    // Handshake: claim/complete are single-cycle strobes with no back-pressure;
    // a strobe whose ID does not address a source in the matching state is dropped.
    always_comb begin
        prev_d = interrupt_source_i;
        mode_d = interrupt_edge_mode_i;
        pend_d = '0;
        svc_d  = '0;
        ovf_d  = ovf_q;
        rise         = interrupt_source_i & ~prev_q;
        mode_chg     = interrupt_edge_mode_i ^ mode_q;
        sat          = '0;
        claim_hit    = '0;
        complete_hit = '0;
        for (int k = 0; k < SOURCES; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            sat[k]          = (cnt_q[k] == CNT_MAX);
            // IDs are 1-based; ID 0 and IDs above SOURCES never match any k.
            claim_hit[k]    = claim_valid_i    && (claim_id_i    == 32'(k + 1));
            complete_hit[k] = complete_valid_i && (complete_id_i == 32'(k + 1));

            // A rise that finds the counter full is lost; remember that it happened.
            if (interrupt_edge_mode_i[k] && !mode_chg[k] && rise[k] && sat[k]) begin
                ovf_d[k] = 1'b1;
            end

            case (state_q[k])
                ST_IDLE: begin
                    if (!interrupt_edge_mode_i[k]) begin
                        if (interrupt_source_i[k]) begin
                            state_d[k] = ST_PENDING;
                        end
                    end else if (cnt_q[k] != CNT_ZERO) begin
                        // Forward one stored edge; a fresh unsaturated rise replaces it.
                        state_d[k] = ST_PENDING;
                        if (!(rise[k] && !sat[k])) begin
                            cnt_d[k] = cnt_q[k] - CNT_ONE;
                        end
                    end else if (rise[k]) begin
                        // Empty counter: the rise itself is forwarded, nothing stored.
                        state_d[k] = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (claim_hit[k]) begin
                        state_d[k] = ST_CLAIMED;
                    end
                    if (interrupt_edge_mode_i[k] && rise[k] && !sat[k]) begin
                        cnt_d[k] = cnt_q[k] + CNT_ONE;
                    end
                end
                ST_CLAIMED: begin
                    if (complete_hit[k]) begin
                        state_d[k] = ST_IDLE;
                    end
                    if (interrupt_edge_mode_i[k] && rise[k] && !sat[k]) begin
                        cnt_d[k] = cnt_q[k] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[k] = ST_IDLE;
                end
            endcase

            // Level sources keep no count; a mode switch discards whatever was stored.
            if (!interrupt_edge_mode_i[k] || mode_chg[k]) begin
                cnt_d[k] = CNT_ZERO;
            end

            pend_d[k] = (state_d[k] == ST_PENDING);
            svc_d[k]  = (state_d[k] == ST_CLAIMED);
        end
    end

    // State, counters and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < SOURCES; k++) begin
                state_q[k] <= ST_IDLE;
                cnt_q[k]   <= CNT_ZERO;
            end
            prev_q <= '0;
            mode_q <= '0;
            pend_q <= '0;
            svc_q  <= '0;
            ovf_q  <= '0;
        end else begin
            for (int k = 0; k < SOURCES; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            prev_q <= prev_d;
            mode_q <= mode_d;
            pend_q <= pend_d;
            svc_q  <= svc_d;
            ovf_q  <= ovf_d;
        end
    end

    // Drive ports from the registers and flatten the per-source FSM states.
    always_comb begin
        interrupt_pending_o       = pend_q;
        interrupt_in_service_o    = svc_q;
        interrupt_edge_overflow_o = ovf_q;
        dbg_state_o               = '0;
        for (int k = 0; k < SOURCES; k++) begin
            dbg_state_o[2*k +: 2] = state_q[k];
        end
    end

endmodule

// File: tb/tb_plic_gateway.sv
// tb_plic_gateway: scenario tasks driving plic_gateway against an expected-output queue.
module tb_plic_gateway;
  localparam int SRC = 31;
  localparam int W   = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic [SRC-1:0]    src;
  logic [SRC-1:0]    mode;
  logic              claim_valid;
  logic [31:0]       claim_id;
  logic              complete_valid;
  logic [31:0]       complete_id;
  logic [SRC-1:0]    pend;
  logic [SRC-1:0]    svc;
  logic [SRC-1:0]    ovf;
  logic [2*SRC-1:0]  dbg_state;

  // expected outputs after the next edge, as the scenarios intend them
  logic [SRC-1:0]    exp_p;
  logic [SRC-1:0]    exp_v;
  logic [SRC-1:0]    exp_o;
  logic [3*SRC-1:0]  exp_q[$];
  int                n_cmp;
  int                n_err;

  plic_gateway #(.SOURCES(SRC), .EDGE_COUNT_WIDTH(W)) dut (
    .clk_i                     (clk),
    .rstn_i                    (rstn),
    .interrupt_source_i        (src),
    .interrupt_edge_mode_i     (mode),
    .claim_valid_i             (claim_valid),
    .claim_id_i                (claim_id),
    .complete_valid_i          (complete_valid),
    .complete_id_i             (complete_id),
    .interrupt_pending_o       (pend),
    .interrupt_in_service_o    (svc),
    .interrupt_edge_overflow_o (ovf),
    .dbg_state_o               (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    claim_valid    = 1'b0;
    complete_valid = 1'b0;
  endtask

  task automatic do_claim(input logic [31:0] id);
    claim_valid = 1'b1;
    claim_id    = id;
  endtask

  task automatic do_complete(input logic [31:0] id);
    complete_valid = 1'b1;
    complete_id    = id;
  endtask

  task automatic test_reset();
    logic [3*SRC-1:0] e, got;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0, 1: begin
          rstn = 1'b0;
          src  = SRC'($urandom);
          do_claim(32'($urandom_range(1, SRC)));
          do_complete(32'($urandom_range(1, SRC)));
        end
        2: begin rstn = 1'b1; src = '0; end
        default: ;
      endcase
      exp_q.push_back({exp_o, exp_v, exp_p});
      tick();
      e = exp_q.pop_front();
      got = {ovf, svc, pend};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL reset step %0d: got ovf=%h svc=%h pend=%h, want ovf=%h svc=%h pend=%h",
                 s, got[3*SRC-1 -: SRC], got[2*SRC-1 -: SRC], got[SRC-1:0],
                 e[3*SRC-1 -: SRC], e[2*SRC-1 -: SRC], e[SRC-1:0]);
      end
    end
  endtask

  task automatic test_level_request();
    logic [3*SRC-1:0] e, got;
    for (int s = 0; s < 8; s++) begin
      case (s)
        0: begin src[2] = 1'b1; exp_p[2] = 1'b1; end
        1: begin do_claim(32'd3); exp_p[2] = 1'b0; exp_v[2] = 1'b1; end
        3: begin do_complete(32'd3); exp_v[2] = 1'b0; end
        4: exp_p[2] = 1'b1;
        5: begin src[2] = 1'b0; do_claim(32'd3); exp_p[2] = 1'b0; exp_v[2] = 1'b1; end
        6: begin do_complete(32'd3); exp_v[2] = 1'b0; end
        default: ;
      endcase
      exp_q.push_back({exp_o, exp_v, exp_p});
      tick();
      e = exp_q.pop_front();
      got = {ovf, svc, pend};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL level_request step %0d: got ovf=%h svc=%h pend=%h, want ovf=%h svc=%h pend=%h",
                 s, got[3*SRC-1 -: SRC], got[2*SRC-1 -: SRC], got[SRC-1:0],
                 e[3*SRC-1 -: SRC], e[2*SRC-1 -: SRC], e[SRC-1:0]);
      end
    end
  endtask

  task automatic test_edge_count();
    logic [3*SRC-1:0] e, got;
    for (int s = 0; s < 20; s++) begin
      if (s == 0) begin
        src[4] = 1'b1; exp_p[4] = 1'b1;
      end else if (s == 1) begin
        src[4] = 1'b0; do_claim(32'd5); exp_p[4] = 1'b0; exp_v[4] = 1'b1;
      end else if (s < 8) begin
        src[4] = (s % 2 == 0);  // three pulses while claimed
      end else if (s == 8) begin
        do_complete(32'd5); exp_v[4] = 1'b0;
      end else if (s < 18) begin
        case ((s - 9) % 3)
          0: exp_p[4] = 1'b1;
          1: begin do_claim(32'd5); exp_p[4] = 1'b0; exp_v[4] = 1'b1; end
          default: begin do_complete(32'd5); exp_v[4] = 1'b0; end
        endcase
      end
      exp_q.push_back({exp_o, exp_v, exp_p});
      tick();
      e = exp_q.pop_front();
      got = {ovf, svc, pend};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL edge_count step %0d: got ovf=%h svc=%h pend=%h, want ovf=%h svc=%h pend=%h",
                 s, got[3*SRC-1 -: SRC], got[2*SRC-1 -: SRC], got[SRC-1:0],
                 e[3*SRC-1 -: SRC], e[2*SRC-1 -: SRC], e[SRC-1:0]);
      end
    end
  endtask

  task automatic test_illegal_ids();
    logic [3*SRC-1:0] e, got;
    for (int s = 0; s < 9; s++) begin
      case (s)
        0: begin src[2] = 1'b1; exp_p[2] = 1'b1; end
        1: begin src[2] = 1'b0; do_claim(32'd0); end       // level drop keeps request
        2: do_claim(32'(SRC + 1));
        3: do_complete(32'd3);                              // not claimed yet
        4: do_claim(32'hFFFF_FFE3);                         // low bits alias ID 3
        5: begin do_claim(32'd3); exp_p[2] = 1'b0; exp_v[2] = 1'b1; end
        6: begin do_claim(32'd3); do_complete(32'd0); end
        7: begin do_complete(32'd3); exp_v[2] = 1'b0; end
        default: ;
      endcase
      exp_q.push_back({exp_o, exp_v, exp_p});
      tick();
      e = exp_q.pop_front();
      got = {ovf, svc, pend};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL illegal_ids step %0d: got ovf=%h svc=%h pend=%h, want ovf=%h svc=%h pend=%h",
                 s, got[3*SRC-1 -: SRC], got[2*SRC-1 -: SRC], got[SRC-1:0],
                 e[3*SRC-1 -: SRC], e[2*SRC-1 -: SRC], e[SRC-1:0]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3*SRC-1:0] e, got;
    for (int s = 0; s < 9; s++) begin
      case (s)
        0: begin src[1] = 1'b1; src[6] = 1'b1; exp_p[1] = 1'b1; exp_p[6] = 1'b1; end
        1: begin src[1] = 1'b0; do_claim(32'd2); exp_p[1] = 1'b0; exp_v[1] = 1'b1; end
        2: begin
          src[6] = 1'b0; do_complete(32'd2); do_claim(32'd7);
          exp_v[1] = 1'b0; exp_p[6] = 1'b0; exp_v[6] = 1'b1;
        end
        4: begin do_complete(32'd7); exp_v[6] = 1'b0; end
        5: begin src[6] = 1'b1; exp_p[6] = 1'b1; end
        6: begin
          src[6] = 1'b0; do_claim(32'd7); do_complete(32'd7);
          exp_p[6] = 1'b0; exp_v[6] = 1'b1;
        end
        7: begin do_claim(32'd7); do_complete(32'd7); exp_v[6] = 1'b0; end
        default: ;
      endcase
      exp_q.push_back({exp_o, exp_v, exp_p});
      tick();
      e = exp_q.pop_front();
      got = {ovf, svc, pend};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL simultaneous step %0d: got ovf=%h svc=%h pend=%h, want ovf=%h svc=%h pend=%h",
                 s, got[3*SRC-1 -: SRC], got[2*SRC-1 -: SRC], got[SRC-1:0],
                 e[3*SRC-1 -: SRC], e[2*SRC-1 -: SRC], e[SRC-1:0]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [3*SRC-1:0] e, got;
    for (int s = 0; s < 84; s++) begin
      if (s == 0) begin
        src[4] = 1'b1; exp_p[4] = 1'b1;
      end else if (s == 1) begin
        src[4] = 1'b0; do_claim(32'd5); exp_p[4] = 1'b0; exp_v[4] = 1'b1;
      end else if (s < 36) begin
        // 17 rises while claimed: the 16th and 17th find the counter at 15
        src[4] = ((s - 2) % 2 == 0);
        if (src[4] && ((s - 2) / 2 + 1) == 16) exp_o[4] = 1'b1;
      end else if (s < 81) begin
        case ((s - 36) % 3)
          0: begin do_complete(32'd5); exp_v[4] = 1'b0; end
          1: exp_p[4] = 1'b1;
          default: begin do_claim(32'd5); exp_p[4] = 1'b0; exp_v[4] = 1'b1; end
        endcase
      end else if (s == 81) begin
        do_complete(32'd5); exp_v[4] = 1'b0;
      end
      exp_q.push_back({exp_o, exp_v, exp_p});
      tick();
      e = exp_q.pop_front();
      got = {ovf, svc, pend};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL saturation step %0d: got ovf=%h svc=%h pend=%h, want ovf=%h svc=%h pend=%h",
                 s, got[3*SRC-1 -: SRC], got[2*SRC-1 -: SRC], got[SRC-1:0],
                 e[3*SRC-1 -: SRC], e[2*SRC-1 -: SRC], e[SRC-1:0]);
      end
    end
  endtask

  task automatic test_reset_mid_service();
    logic [3*SRC-1:0] e, got;
    for (int s = 0; s < 9; s++) begin
      case (s)
        0: begin src[0] = 1'b1; exp_p[0] = 1'b1; end
        1: begin
          src[0] = 1'b0; src[8] = 1'b1; do_claim(32'd1);
          exp_p[0] = 1'b0; exp_v[0] = 1'b1; exp_p[8] = 1'b1;
        end
        2: begin do_claim(32'd9); exp_p[8] = 1'b0; exp_v[8] = 1'b1; end
        3: begin rstn = 1'b0; exp_p = '0; exp_v = '0; exp_o = '0; end
        4: begin rstn = 1'b1; exp_p[8] = 1'b1; end  // held-high edge source seen as a rise
        5: begin do_claim(32'd9); exp_p[8] = 1'b0; exp_v[8] = 1'b1; end
        6: begin do_complete(32'd9); exp_v[8] = 1'b0; end
        8: src[8] = 1'b0;
        default: ;
      endcase
      exp_q.push_back({exp_o, exp_v, exp_p});
      tick();
      e = exp_q.pop_front();
      got = {ovf, svc, pend};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL reset_mid_service step %0d: got ovf=%h svc=%h pend=%h, want ovf=%h svc=%h pend=%h",
                 s, got[3*SRC-1 -: SRC], got[2*SRC-1 -: SRC], got[SRC-1:0],
                 e[3*SRC-1 -: SRC], e[2*SRC-1 -: SRC], e[SRC-1:0]);
      end
    end
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    rstn           = 1'b0;
    src            = '0;
    mode           = 31'h0000_0110;  // IDs 5 and 9 edge-triggered, all others level
    claim_valid    = 1'b0;
    claim_id       = '0;
    complete_valid = 1'b0;
    complete_id    = '0;
    exp_p          = '0;
    exp_v          = '0;
    exp_o          = '0;

    test_reset();
    test_level_request();
    test_edge_count();
    test_illegal_ids();
    test_simultaneous();
    test_saturation();
    test_reset_mid_service();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/plic_gateway.md
# plic_gateway

Per-source interrupt gateway array for the PLIC, sitting directly upstream of the priority comparator tree. It converts raw interrupt lines, level or edge, into one pending request per source and holds at most one request outstanding until the target completes it. It also tracks claim/complete per source and counts edges that arrive while a request is in flight. Its `interrupt_pending_o` bits drive the `interrupt_pending_i` inputs of the comparator cells.

## Interface
- `SOURCES`, 31: number of sources. Interrupt ID k (1..SOURCES) maps to bit k-1. ID 0 is reserved (no interrupt).
- `EDGE_COUNT_WIDTH`, 4: width of the per-source edge counter. Saturates at 2^W-1.

- `clk_i` input 1: single clock.
- `rstn_i` input 1: reset, synchronous, active-low.
- `interrupt_source_i` input SOURCES: raw interrupt lines, already synchronous to `clk_i`.
- `interrupt_edge_mode_i` input SOURCES: per-source mode. 1 = rising-edge triggered, 0 = level (active-high).
- `claim_valid_i` input 1: one-cycle claim strobe from the target's claim read.
- `claim_id_i` input 32: ID being claimed.
- `complete_valid_i` input 1: one-cycle completion strobe.
- `complete_id_i` input 32: ID being completed.
- `interrupt_pending_o` output SOURCES: pending request per source. Registered.
- `interrupt_in_service_o` output SOURCES: source claimed, completion outstanding. Registered.
- `interrupt_edge_overflow_o` output SOURCES: sticky flag, set when an edge arrives while the counter is saturated.

## Operation
- Each source runs an independent 3-state FSM:
  - **IDLE**: ready to forward a request.
  - **PENDING**: request forwarded; `interrupt_pending_o`=1.
  - **CLAIMED**: in service; `interrupt_in_service_o`=1.
- Edge detect: `prev` register samples `interrupt_source_i` every cycle. `rise` = src & ~prev.
- Edge counter (edge mode only):
  - Increments on `rise` unless saturated.
  - If saturated and `rise`, sets the overflow flag and the count stays at max.
  - In level mode the counter is held at 0.
- **IDLE → PENDING**:
  - Level mode: when src=1.
  - Edge mode: when count>0 or `rise`. Forwarding consumes one edge: next count = count − (count>0 ? 1 : 0) + (`rise` & count>0 & !saturated). With count==0 and `rise`, the edge is forwarded directly and count stays 0.
- **PENDING → CLAIMED**: on `claim_valid_i` with `claim_id_i`==k. The pending bit clears.
- **CLAIMED → IDLE**: on `complete_valid_i` with `complete_id_i`==k.
- Ignored inputs:
  - Claim for a source not in PENDING.
  - Complete for a source not in CLAIMED.
  - ID 0 or ID > SOURCES, in either strobe.
- Level-mode source deasserting while PENDING: the request stays PENDING. The gateway does not retract requests.
- Edges during PENDING/CLAIMED are counted, not forwarded.
- Claim and complete in the same cycle:
  - Different IDs: both applied.
  - Same ID: only the transition valid for the current state is applied. Never two transitions in one cycle.
- `interrupt_edge_mode_i` is static configuration. Changing it on a non-IDLE source leaves the FSM state intact and clears the counter.
- Reset (`rstn_i`=0 at a rising edge):
  - All FSMs go to IDLE.
  - Counters, `prev` and all three outputs go to 0.
  - Reset mid-claim discards in-flight state with no completion required.
  - Because `prev` resets to 0, an edge-mode source held high through reset is seen as one edge on the first cycle after release.

## Timing
- Latency, source to pending:
  - Level: src=1 sampled at edge n → `interrupt_pending_o`=1 after edge n.
  - Edge: the rising transition seen at edge n → pending after edge n.
- Latency, claim to pending clear: `claim_valid_i` sampled at edge n → pending=0 and in_service=1 after edge n.
- Latency, complete to IDLE: after edge n. The earliest re-forward is edge n+1, so there is at least one cycle with pending=0 between consecutive requests of one source.
- Overflow flag: sticky, set the same edge the lost rise is sampled; cleared only by reset.
- No combinational input-to-output paths.

## Test plan
- **Reset and level request**: hold `rstn_i`=0 for 2 cycles → all outputs 0. Then level source 3 high, claim ID 3, complete ID 3 with source still high → pending after 1 cycle, pending→0/in_service→1 after claim, pending=1 again 2 edges after complete.
- **Edge counting**: on edge-mode source 5, issue 3 pulses while CLAIMED → count=3. Each complete/claim cycle re-forwards one request. After three services the count is 0 and there is no further pending.
- **Saturation**: with W=4, issue 17 rises while CLAIMED → count=15, `interrupt_edge_overflow_o[4]`=1, and the flag stays set through later completes until reset.
- **Illegal IDs**: claim ID 0, claim ID SOURCES+1, and complete on a PENDING source → no state change on any source.
- **Simultaneous events**: complete ID 2 and claim ID 7 in the same cycle → both transition. Same-cycle claim+complete of ID 7 while PENDING → CLAIMED only.
- **Reset mid-service**: source 1 CLAIMED, pulse `rstn_i` low 1 cycle → in_service=0. An edge-mode source held high re-forwards once after release.
